// File: rtl/pulse_divider_rp.sv
// pulse_divider_rp: serially programmed clock divider with toggle/pulse output and row-packing freeze
module pulse_divider_rp #(
  parameter int DIV_WIDTH = 32,
  parameter int ROW_WIDTH = 16,
  parameter int RESET_DIV = 2
) (
  input  logic                 pulse_clock,
  input  logic                 external_reset_n,
  input  logic                 enable,
  input  logic                 pulse_mode,
  input  logic                 sr_data,
  input  logic                 sr_shift,
  input  logic                 sr_sel,
  input  logic                 sr_commit,
  input  logic                 rowpack_enable,
  input  logic                 reset_row,
  output logic                 divided_clock,
  output logic                 row_complete,
  output logic [ROW_WIDTH-1:0] row_count,
  output logic                 load_pending
);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = 1;
  localparam logic [ROW_WIDTH-1:0] ROW_ONE = 1;
  logic [DIV_WIDTH-1:0] div_sr, div_pend, div_n, cnt;
  logic [ROW_WIDTH-1:0] row_sr, row_pend, row_r;
  logic act_mode, pm_q;
  logic frozen, run, term, change, apply, row_ev, row_last, dc_next;
  always_comb begin
    frozen   = row_complete && rowpack_enable;
    run      = enable && !frozen && div_n != '0;
    term     = run && cnt == div_n - DIV_ONE;
    change   = pulse_mode != pm_q;
    apply    = load_pending && (term || !enable);
    row_ev   = term && rowpack_enable && !change && (pulse_mode || !divided_clock);
    row_last = row_r != '0 && row_count == row_r - ROW_ONE;
    dc_next  = (frozen || change || div_n == '0) ? 1'b0 :
               term ? (pulse_mode || !divided_clock) : (!act_mode && divided_clock);
  end
  always_ff @(posedge pulse_clock) begin
    if (!external_reset_n) begin
      div_sr        <= '0;
      row_sr        <= '0;
      div_pend      <= '0;
      row_pend      <= '0;
      load_pending  <= 1'b0;
      div_n         <= DIV_WIDTH'(RESET_DIV);
      row_r         <= '0;
      cnt           <= '0;
      divided_clock <= 1'b0;
      row_count     <= '0;
      row_complete  <= 1'b0;
      act_mode      <= pulse_mode;
      pm_q          <= pulse_mode;
    end else begin
      pm_q <= pulse_mode;
      if (term) act_mode <= pulse_mode;
      if (sr_shift && !sr_sel) div_sr <= {div_sr[DIV_WIDTH-2:0], sr_data};
      if (sr_shift && sr_sel) row_sr <= (row_sr << 1) | ROW_WIDTH'(sr_data);
      if (apply) begin
        div_n <= div_pend;
        row_r <= row_pend;
      end
      if (sr_commit) begin
        div_pend <= div_sr;
        row_pend <= row_sr;
      end
      load_pending  <= sr_commit || (load_pending && !apply);
      cnt           <= (apply || term) ? '0 : run ? cnt + DIV_ONE : cnt;
      divided_clock <= dc_next;
      if (reset_row) begin
        row_count    <= '0;
        row_complete <= 1'b0;
      end else if (row_ev) begin
        row_count    <= row_last ? '0 : row_count + ROW_ONE;
        row_complete <= row_last;
      end
    end
  end
endmodule
